// File: rtl/gen_buffer_sequencer_pkg.sv
// Shared constants, types and ring-index helper for the generation-buffer sequencer.
package gen_buffer_sequencer_pkg;

    localparam int unsigned DEF_NUM_BUFS = 3;
    localparam int unsigned DEF_SPEED_W  = 4;
    localparam int unsigned DEF_GEN_W    = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef logic [DEF_SPEED_W-1:0] speed_t;
    typedef logic [DEF_GEN_W-1:0]   gen_count_t;

    // Modulo-n increment; n need not be a power of two.
    function automatic int unsigned ring_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/gen_buffer_sequencer_frame_pacer.sv
// Frame pacer: decides on which frame_start the displayed generation may advance,
// based on speed, pause and a latched single-step request.
module gen_buffer_sequencer_frame_pacer #(
    parameter int unsigned SPEED_W = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [SPEED_W-1:0] speed_in,
    input  logic               pause_in,
    input  logic               step_in,
    input  logic               frame_start_in,
    input  logic               pending_nonzero_in,
    output logic               advance_c
);

    localparam int unsigned CNT_W = SPEED_W + 1;

    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] period_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             due_c;
    logic             step_latch;

    // Period ranges 1 (fastest) .. 2^SPEED_W (slowest) frames.
    assign period_c  = (CNT_W'(1) << SPEED_W) - CNT_W'(speed_in);
    assign cnt_inc_c = frame_cnt + CNT_W'(1);
    assign due_c     = (cnt_inc_c >= period_c);
    assign advance_c = frame_start_in && pending_nonzero_in && (pause_in ? step_latch : due_c);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            frame_cnt  <= '0;
            step_latch <= 1'b0;
        end else begin
            // Saturate at period so an overdue advance fires on the next usable frame.
            if (advance_c) begin
                frame_cnt <= '0;
            end else if (frame_start_in) begin
                frame_cnt <= due_c ? period_c : cnt_inc_c;
            end

            if (!pause_in) begin
                step_latch <= 1'b0;
            end else if (step_in) begin
                step_latch <= 1'b1;
            end else if (advance_c) begin
                step_latch <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gen_buffer_sequencer.sv
// N-way generation-buffer sequencer: owns the buffer ring between the life engine
// and the renderer, runs the engine ahead of the display and publishes at frame starts.
module gen_buffer_sequencer
    import gen_buffer_sequencer_pkg::*;
#(
    parameter  int unsigned NUM_BUFS = DEF_NUM_BUFS,
    parameter  int unsigned SPEED_W  = DEF_SPEED_W,
    parameter  int unsigned GEN_W    = DEF_GEN_W,
    localparam int unsigned BUF_W    = $clog2(NUM_BUFS)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [SPEED_W-1:0] speed_in,
    input  logic               pause_in,
    input  logic               step_in,
    input  logic               edit_in,
    input  logic               frame_start_in,
    input  logic               logic_done_in,
    output logic               logic_start_out,
    output logic [BUF_W-1:0]   logic_rd_buf_out,
    output logic [BUF_W-1:0]   logic_wr_buf_out,
    output logic [BUF_W-1:0]   render_buf_out,
    output logic [BUF_W:0]     pending_out,
    output logic [GEN_W-1:0]   gen_count_out,
    output logic               busy_out
);

    localparam int unsigned       PEND_W   = BUF_W + 1;
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(NUM_BUFS - 1);

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [BUF_W-1:0]  disp_q;
    logic [BUF_W-1:0]  disp_d;
    logic [BUF_W-1:0]  head_q;
    logic [BUF_W-1:0]  head_d;
    logic [PEND_W-1:0] pend_d;
    logic              flush_pend_q;
    logic              flush_pend_d;
    logic              start_c;
    logic              done_c;
    logic              flush_c;
    logic              advance_c;

    gen_buffer_sequencer_frame_pacer #(
        .SPEED_W (SPEED_W)
    ) u_pacer (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .speed_in           (speed_in),
        .pause_in           (pause_in),
        .step_in            (step_in),
        .frame_start_in     (frame_start_in),
        .pending_nonzero_in (pending_out != '0),
        .advance_c          (advance_c)
    );

    // Engine FSM: launch whenever a free buffer exists and no flush is outstanding.
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush_pend_q && !edit_in && (pending_out < PEND_MAX)) begin
                    state_d = ST_RUN;
                    start_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (logic_done_in) begin
                    state_d = ST_IDLE;
                    done_c  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Index ring; a flush waits for IDLE so an in-flight run always completes first.
    always_comb begin
        flush_c      = (state_q == ST_IDLE) && flush_pend_q;
        disp_d       = advance_c ? BUF_W'(ring_inc(32'(disp_q), NUM_BUFS)) : disp_q;
        head_d       = done_c ? BUF_W'(ring_inc(32'(head_q), NUM_BUFS)) : head_q;
        pend_d       = pending_out + PEND_W'(done_c) - PEND_W'(advance_c);
        flush_pend_d = flush_pend_q;
        if (flush_c) begin
            head_d       = disp_d;
            pend_d       = '0;
            flush_pend_d = 1'b0;
        end
        if (edit_in) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= ST_IDLE;
            disp_q          <= '0;
            head_q          <= '0;
            pending_out     <= '0;
            flush_pend_q    <= 1'b0;
            gen_count_out   <= '0;
            logic_start_out <= 1'b0;
            busy_out        <= 1'b0;
        end else begin
            state_q         <= state_d;
            disp_q          <= disp_d;
            head_q          <= head_d;
            pending_out     <= pend_d;
            flush_pend_q    <= flush_pend_d;
            logic_start_out <= start_c;
            busy_out        <= (state_d == ST_RUN);
            if (advance_c) begin
                gen_count_out <= gen_count_out + GEN_W'(1);
            end
        end
    end

    assign render_buf_out   = disp_q;
    assign logic_rd_buf_out = head_q;
    assign logic_wr_buf_out = BUF_W'(ring_inc(32'(head_q), NUM_BUFS));

endmodule

// File: doc/gen_buffer_sequencer.md
Name: gen_buffer_sequencer

Overview:
Parametrised N-way generation-buffer sequencer. It replaces the fixed two-buffer swap between life_logic and renderer. It owns buffer indices and lets the life engine compute up to NUM_BUFS-1 generations ahead of the displayed one. It paces display advances by speed, supports pause, single-step and edit-flush, and publishes new generations only at frame boundaries.

Parameters:
NUM_BUFS, 3, number of generation buffers (legal 2..8).
BUF_W, $clog2(NUM_BUFS), buffer-index width (derived, not overridden).
SPEED_W, 4, width of speed_in.
GEN_W, 16, width of generation counter.

Ports:
clk_in  input  1  system clock (25 MHz domain)
rst_in  input  1  synchronous active-high reset
speed_in  input  SPEED_W  0 = slowest, 2^SPEED_W-1 = fastest
pause_in  input  1  level; blocks paced display advances
step_in  input  1  one-cycle pulse; single advance while paused
edit_in  input  1  one-cycle pulse; discard precomputed generations
frame_start_in  input  1  one-cycle pulse at start of vertical blank
logic_done_in  input  1  one-cycle pulse; engine finished current generation
logic_start_out  output  1  one-cycle pulse; engine begins a generation
logic_rd_buf_out  output  BUF_W  buffer the engine reads
logic_wr_buf_out  output  BUF_W  buffer the engine writes
render_buf_out  output  BUF_W  buffer the renderer displays
pending_out  output  BUF_W+1  completed generations not yet displayed
gen_count_out  output  GEN_W  displayed-generation number
busy_out  output  1  engine run in progress

Behaviour:
- State: disp (displayed index), head (newest completed index), pending (0..NUM_BUFS-1). Invariant: head = (disp + pending) mod NUM_BUFS.
- All index arithmetic is modulo NUM_BUFS. Do not use power-of-two masking.
- render_buf_out = disp. logic_rd_buf_out = head. logic_wr_buf_out = (head+1) mod NUM_BUFS.
- Engine FSM has two states, IDLE and RUN.
  - IDLE -> RUN when pending < NUM_BUFS-1 and flush not pending. logic_start_out pulses for exactly that one cycle.
  - rd/wr outputs are held stable for the whole of RUN.
  - RUN -> IDLE on logic_done_in. In that cycle head advances and pending increments.
  - The earliest restart is 1 cycle after returning to IDLE, so consecutive starts are at least 2 cycles apart.
  - logic_done_in received in IDLE is ignored.
- Pacer: period = 2^SPEED_W - speed_in frames, so speed 15 = every frame and speed 0 = every 16 frames (SPEED_W=4).
  - frame_cnt increments on frame_start_in and saturates at period.
  - Advance on frame_start_in when frame_cnt+1 >= period, pause_in=0 and pending>0. On advance: frame_cnt clears, disp increments, pending decrements, gen_count_out increments (wraps).
  - If due but pending==0: no advance; frame_cnt holds, so the advance happens on the first frame_start_in after a generation completes.
- Step:
  - step_in while pause_in=1 sets step_latch.
  - On frame_start_in with step_latch=1 and pending>0: one advance, latch cleared.
  - Step while unpaused is ignored. Repeated steps before consumption collapse to one.
- Simultaneous done + advance in the same cycle: pending is unchanged, head and disp both increment.
- Edit flush:
  - edit_in sets flush_pend and suppresses new starts.
  - On the first cycle in IDLE with flush_pend=1: head←disp, pending←0, flush_pend cleared.
  - A done arriving in the same cycle as edit_in completes the run normally; the flush then applies next cycle.
- Reset (any state, including mid-RUN): disp=0, head=0, pending=0, IDLE, frame_cnt=0, step_latch=0, flush_pend=0, gen_count_out=0, logic_start_out=0, logic_rd_buf_out=0, logic_wr_buf_out=1, render_buf_out=0, busy_out=0. A stale logic_done_in after reset is ignored (IDLE).
- All outputs are registered except the rd/wr/render indices, which are combinational from state registers.

Decomposition:
- common.svh: speed_t sized by SPEED_W, gen_count_t.
- Sub-module frame_pacer: frame_cnt, period compute, step_latch. Inputs speed/pause/step/frame_start/pending_nonzero; output advance pulse.
- Top of gen_buffer_sequencer: engine FSM, index ring, flush.

Test Plan:
- Reset, NUM_BUFS=3, done returned 10 cycles after each start, no frames -> exactly 2 starts; pending_out=2; wr index 1 then 2; no third start.
- Continue with speed_in=15 and frame_start_in every 100 cycles -> render_buf_out 0→1→2→0…, gen_count_out +1 per frame, pending oscillates 1..2 and never exceeds 2.
- speed_in=13 -> advances on every 3rd frame_start_in; speed_in=0 -> every 16th.
- pause_in=1, pending=2, two step_in pulses before the next frame -> exactly one advance; gen_count_out +1; pending=1.
- edit_in pulse during RUN with pending=1 -> no new start; on done pending briefly 2, then next cycle pending=0, head=disp, then one new start with wr=disp+1.
- NUM_BUFS=2: done in same cycle as advance -> pending stays 1; render_buf_out and logic_rd_buf_out both toggle; reset asserted mid-RUN -> all outputs at reset values, later done ignored.
